// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state type and default stream widths for the packet arbiter
package axis_arb_pkg;
    typedef enum logic {IDLE, BUSY} arb_state_t;
    localparam int AXIS_DATA_W = 8;
    localparam int AXIS_KEEP_W = 2;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first requester at or after ptr
module rr_priority_picker #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt_id,
    output logic            any_req
);
    localparam int W1 = ID_W + 1;
    logic [2*N-1:0] dbl;
    logic [W1-1:0]  off, sum;
    always_comb begin
        // doubling the request vector makes the wrap N-1 -> 0 a plain shift
        dbl = {req, req} >> ptr;
        off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (dbl[i]) off = W1'(i);
        sum = {1'b0, ptr} + off;
        gnt_id = (sum >= W1'(N)) ? ID_W'(sum - W1'(N)) : ID_W'(sum);
        any_req = |req;
    end
endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// axis_pkt_rr_arbiter: packet-level round-robin sharing of one AXI-Stream sink among N_SRC masters
module axis_pkt_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = AXIS_DATA_W,
    parameter int KEEP_W = AXIS_KEEP_W,
    parameter int ID_W   = $clog2(N_SRC)
) (
    input  logic                    Aclk,
    input  logic                    Areset_n,
    input  logic [N_SRC-1:0]        s_axis_tvalid,
    input  logic [N_SRC-1:0]        s_axis_tlast,
    input  logic [N_SRC*DATA_W-1:0] s_axis_tdata,
    input  logic [N_SRC*KEEP_W-1:0] s_axis_tkeep,
    output logic [N_SRC-1:0]        s_axis_tready,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic [DATA_W-1:0]       m_axis_tdata,
    output logic [KEEP_W-1:0]       m_axis_tkeep,
    input  logic                    m_axis_tready,
    output logic [ID_W-1:0]         m_axis_tid,
    output logic                    pkt_done
);
    arb_state_t      state, next_state;
    logic [ID_W-1:0] grant_id, rr_ptr, pick_id;
    logic            any_req, hs;

    rr_priority_picker #(.N(N_SRC), .ID_W(ID_W)) u_picker (
        .req     (s_axis_tvalid),
        .ptr     (rr_ptr),
        .gnt_id  (pick_id),
        .any_req (any_req)
    );

    always_comb begin
        next_state    = state;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        hs            = 1'b0;
        if (state == BUSY) begin
            m_axis_tvalid           = s_axis_tvalid[grant_id];
            m_axis_tlast            = s_axis_tlast[grant_id];
            m_axis_tdata            = s_axis_tdata[int'(grant_id)*DATA_W +: DATA_W];
            m_axis_tkeep            = s_axis_tkeep[int'(grant_id)*KEEP_W +: KEEP_W];
            s_axis_tready[grant_id] = m_axis_tready;
            hs                      = m_axis_tvalid & m_axis_tready;
            next_state              = (hs && m_axis_tlast) ? IDLE : BUSY;
        end else begin
            next_state = any_req ? BUSY : IDLE;
        end
    end

    assign m_axis_tid = grant_id;

    always_ff @(posedge Aclk) begin
        if (!Areset_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            pkt_done <= 1'b0;
        end else begin
            state    <= next_state;
            pkt_done <= hs & m_axis_tlast;
            if (state == IDLE && any_req)
                grant_id <= pick_id;
            // explicit wrap keeps the pointer legal for non-power-of-2 N_SRC
            if (hs && m_axis_tlast)
                rr_ptr <= (grant_id == ID_W'(N_SRC - 1)) ? '0 : grant_id + 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// tb_axis_pkt_rr_arbiter: directed checks of grant order, backpressure, bubbles and reset
module tb_axis_pkt_rr_arbiter;
    logic        Aclk = 1'b0;
    logic        Areset_n = 1'b0;
    logic [3:0]  s_tvalid, s_tlast, s_tready;
    logic [31:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        m_tvalid, m_tlast, m_tready;
    logic [7:0]  m_tdata;
    logic [1:0]  m_tkeep, m_tid;
    logic        pkt_done;
    logic [3:0]  en;
    int          len [4];
    int          cnt [4];
    logic [7:0]  base [4];
    int          total = 0;
    int          bad = 0;

    always #5 Aclk = ~Aclk;

    axis_pkt_rr_arbiter dut (
        .Aclk          (Aclk),
        .Areset_n      (Areset_n),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tready (s_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tready (m_tready),
        .m_axis_tid    (m_tid),
        .pkt_done      (pkt_done)
    );

    // stimulus sources: each emits packets of len[i] beats, data base[i]+beat, keep = i
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i]         = en[i];
            s_tlast[i]          = (cnt[i] == len[i] - 1);
            s_tdata[i*8 +: 8]   = base[i] + 8'(cnt[i]);
            s_tkeep[i*2 +: 2]   = 2'(i);
        end
    end

    always @(posedge Aclk) begin
        for (int i = 0; i < 4; i++) begin
            if (!Areset_n) cnt[i] <= 0;
            else if (s_tvalid[i] && s_tready[i]) cnt[i] <= s_tlast[i] ? 0 : cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  src, ph, got;
        bit  done;
        base = '{8'h00, 8'h10, 8'hA0, 8'h30};
        len  = '{2, 2, 2, 2};
        en = 4'hF;
        m_tready = 1'b1;
        // reset held with every source requesting
        repeat (2) begin
            tick();
            check("rst_tready", 32'(s_tready), 32'h0);
            check("rst_mvalid", 32'(m_tvalid), 32'h0);
            check("rst_tid", 32'(m_tid), 32'h0);
            check("rst_pd", 32'(pkt_done), 32'h0);
        end
        Areset_n = 1'b1;
        // fairness: 2-beat packets, 3 cycles per packet
        for (int k = 0; k <= 12; k++) begin
            tick();
            src = (k / 3) % 4;
            ph  = k % 3;
            check("fair_tid", 32'(m_tid), 32'(src));
            check("fair_valid", 32'(m_tvalid), 32'(ph != 2));
            check("fair_pd", 32'(pkt_done), 32'(ph == 2));
            if (ph != 2) begin
                check("fair_data", 32'(m_tdata), 32'(8'(base[src] + 8'(ph))));
                check("fair_keep", 32'(m_tkeep), 32'(src));
                check("fair_last", 32'(m_tlast), 32'(ph == 1));
            end
        end
        // wrap and skip: only sources 1 and 3, single-beat packets
        Areset_n = 1'b0;
        tick();
        Areset_n = 1'b1;
        en = 4'b1010;
        len = '{1, 1, 1, 1};
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 0) begin
                src = (k % 4 == 0) ? 1 : 3;
                check("wrap_tid", 32'(m_tid), 32'(src));
                check("wrap_tready", 32'(s_tready), 32'(1 << src));
                check("wrap_last", 32'(m_tlast), 32'h1);
            end else begin
                check("wrap_idle_valid", 32'(m_tvalid), 32'h0);
                check("wrap_pd", 32'(pkt_done), 32'h1);
            end
        end
        // backpressure: source 2 sends A0..A3 with ready 1,0,0,1,...
        Areset_n = 1'b0;
        en = 4'b0000;
        tick();
        Areset_n = 1'b1;
        en = 4'b0100;
        len = '{2, 2, 4, 2};
        m_tready = 1'b1;
        got = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            check("bp_tid", 32'(m_tid), 32'h2);
            check("bp_tready", 32'(s_tready), m_tready ? 32'h4 : 32'h0);
            if (m_tvalid && m_tready) begin
                check("bp_data", 32'(m_tdata), 32'(8'(8'hA0 + 8'(got))));
                got++;
                if (m_tlast) done = 1'b1;
            end
            m_tready = ((k + 1) % 3 == 0);
            if (k == 0) en[0] = 1'b1;
        end
        check("bp_beats", 32'(got), 32'd4);
        check("bp_done", 32'(done), 32'h1);
        m_tready = 1'b1;
        tick();
        check("bp_pd", 32'(pkt_done), 32'h1);
        check("bp_idle_tready", 32'(s_tready), 32'h0);
        tick();
        check("bp_next_tid", 32'(m_tid), 32'h0);
        check("bp_next_tready", 32'(s_tready), 32'h1);
        // source bubble: source 1 drops valid for 3 cycles while source 0 waits
        Areset_n = 1'b0;
        en = 4'b0000;
        tick();
        Areset_n = 1'b1;
        en = 4'b0010;
        len = '{5, 4, 2, 2};
        for (int k = 0; k <= 6; k++) begin
            tick();
            check("bub_tid", 32'(m_tid), 32'h1);
            check("bub_tready0", 32'(s_tready[0]), 32'h0);
            check("bub_valid", 32'(m_tvalid), 32'(!(k >= 1 && k <= 3)));
            if (k == 6) begin
                check("bub_last", 32'(m_tlast), 32'h1);
                check("bub_data", 32'(m_tdata), 32'h13);
            end
            if (k == 0) en[0] = 1'b1;
            en[1] = !((k + 1) >= 1 && (k + 1) <= 3);
        end
        tick();
        check("bub_pd", 32'(pkt_done), 32'h1);
        check("bub_idle_valid", 32'(m_tvalid), 32'h0);
        tick();
        check("bub_next_tid", 32'(m_tid), 32'h0);
        check("bub_next_data", 32'(m_tdata), 32'h00);
        tick();
        check("mid_beat1", 32'(m_tdata), 32'h01);
        // reset during the second beat of source 0's 5-beat packet
        Areset_n = 1'b0;
        en = 4'b1010;
        len = '{5, 1, 1, 1};
        tick();
        check("mid_tready", 32'(s_tready), 32'h0);
        check("mid_valid", 32'(m_tvalid), 32'h0);
        check("mid_last", 32'(m_tlast), 32'h0);
        check("mid_data", 32'(m_tdata), 32'h0);
        check("mid_keep", 32'(m_tkeep), 32'h0);
        check("mid_tid", 32'(m_tid), 32'h0);
        check("mid_pd", 32'(pkt_done), 32'h0);
        Areset_n = 1'b1;
        tick();
        check("mid_restart_tid", 32'(m_tid), 32'h1);
        check("mid_restart_valid", 32'(m_tvalid), 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
